// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: clips a solid-colour rectangle to the framebuffer
// and writes it through port A at one pixel per clock.
module fb_rect_fill #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [8:0]        x0,
    input  logic [7:0]        y0,
    input  logic [8:0]        width,
    input  logic [7:0]        height,
    input  logic [PIX_W-1:0]  color,
    input  logic              sync_vblank,
    input  logic              vblank,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_data,
    output logic              fb_we
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VB,
        SETUP,
        FILL,
        DONE
    } state_t;

    localparam logic [8:0]        H_LIM  = 9'(H_RES);
    localparam logic [7:0]        V_LIM  = 8'(V_RES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    state_t             state;
    logic [8:0]         x0_q;
    logic [7:0]         y0_q;
    logic [8:0]         w_q;
    logic [7:0]         h_q;
    logic [PIX_W-1:0]   color_q;
    logic [8:0]         x_cur;
    logic [8:0]         col_left;
    logic [7:0]         row_left;
    logic [8:0]         w_eff_q;
    logic [ADDR_W-1:0]  row_base;

    logic               x_out;
    logic               y_out;
    logic [8:0]         x_room;
    logic [7:0]         y_room;
    logic [8:0]         w_eff;
    logic [7:0]         h_eff;
    logic [ADDR_W-1:0]  base_init;

    // Clip against the screen edges using the latched request.
    always_comb begin
        x_out  = (x0_q >= H_LIM);
        y_out  = (y0_q >= V_LIM);
        x_room = H_LIM - x0_q;
        y_room = V_LIM - y0_q;
        w_eff  = 9'd0;
        h_eff  = 8'd0;
        if (!x_out) begin
            w_eff = (w_q < x_room) ? w_q : x_room;
        end
        if (!y_out) begin
            h_eff = (h_q < y_room) ? h_q : y_room;
        end
        if (H_RES == 320) begin
            base_init = (ADDR_W'(y0_q) << 8) + (ADDR_W'(y0_q) << 6);
        end else begin
            base_init = ADDR_W'(y0_q) * H_STEP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            x_cur    <= '0;
            col_left <= '0;
            row_left <= '0;
            w_eff_q  <= '0;
            row_base <= '0;
        end else begin
            fb_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x0_q    <= x0;
                        y0_q    <= y0;
                        w_q     <= width;
                        h_q     <= height;
                        color_q <= color;
                        state   <= sync_vblank ? WAIT_VB : SETUP;
                    end
                end
                WAIT_VB: begin
                    busy <= 1'b1;
                    if (vblank) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    busy     <= 1'b1;
                    x_cur    <= x0_q;
                    col_left <= w_eff;
                    row_left <= h_eff;
                    w_eff_q  <= w_eff;
                    row_base <= base_init;
                    if (x_out || y_out || w_eff == 9'd0 || h_eff == 8'd0) begin
                        state <= DONE;
                    end else begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    fb_we   <= 1'b1;
                    fb_addr <= row_base + ADDR_W'(x_cur);
                    fb_data <= color_q;
                    if (col_left == 9'd1) begin
                        if (row_left == 8'd1) begin
                            state <= DONE;
                        end else begin
                            row_left <= row_left - 8'd1;
                            col_left <= w_eff_q;
                            x_cur    <= x0_q;
                            row_base <= row_base + H_STEP;
                        end
                    end else begin
                        col_left <= col_left - 9'd1;
                        x_cur    <= x_cur + 9'd1;
                    end
                end
                DONE: begin
                    // Hold DONE through the pulse so a start during it is dropped.
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: table of fills checked through a write scoreboard,
// plus vblank-sync and reset-mid-fill sequences.
module tb_fb_rect_fill;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  width;
    logic [7:0]  height;
    logic [11:0] color;
    logic        sync_vblank;
    logic        vblank;
    logic        busy;
    logic        done;
    logic [16:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_we;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        int x0;
        int y0;
        int w;
        int h;
        int color;
        int exp_n;
        int exp_first;
    } vec_t;
    vec_t vecs[9];

    fb_rect_fill dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .x0(x0),
        .y0(y0),
        .width(width),
        .height(height),
        .color(color),
        .sync_vblank(sync_vblank),
        .vblank(vblank),
        .busy(busy),
        .done(done),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .fb_we(fb_we)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Every write must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (fb_we === 1'b1) begin
            wr_t e;
            wr_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0h", fb_addr, fb_data);
            end else begin
                e = sb.pop_front();
                if (int'(fb_addr) != e.addr || int'(fb_data) != e.data) begin
                    errors++;
                    $display("FAIL write actual=%0d/%0h required=%0d/%0h",
                             fb_addr, fb_data, e.addr, e.data);
                end
            end
        end
    end

    // Reference clip, addresses via true multiply; limit caps pushed entries.
    task automatic push_model(input int px, input int py, input int pw,
                              input int ph, input int pc, input int limit,
                              output int n);
        int we;
        int he;
        we = (px >= 320) ? 0 : ((pw > 320 - px) ? 320 - px : pw);
        he = (py >= 240) ? 0 : ((ph > 240 - py) ? 240 - py : ph);
        n = we * he;
        for (int r = 0; r < he; r++) begin
            for (int c = 0; c < we; c++) begin
                if (r * we + c < limit) begin
                    sb.push_back('{addr: (py + r) * 320 + px + c, data: pc});
                end
            end
        end
    endtask

    task automatic drive_req(input int px, input int py, input int pw,
                             input int ph, input int pc, input logic sync);
        x0          = 9'(px);
        y0          = 8'(py);
        width       = 9'(pw);
        height      = 8'(ph);
        color       = 12'(pc);
        sync_vblank = sync;
        start       = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_fill(input int px, input int py, input int pw,
                            input int ph, input int pc,
                            input int exp_n, input int exp_first);
        int n;
        int k;
        int kdone;
        int kfirst;
        int afirst;
        int w0;
        push_model(px, py, pw, ph, pc, 1 << 30, n);
        chk("model_n", n, exp_n);
        w0 = wr_count;
        drive_req(px, py, pw, ph, pc, 1'b0);
        k = 0;
        kdone = -1;
        kfirst = -1;
        afirst = -1;
        while (kdone < 0 && k < 2000) begin
            @(negedge clock); #1;
            k++;
            if (k == 1) chk("busy_edge1", int'(busy), 1);
            if (exp_n > 0 && k == 1 + exp_n) chk("busy_last", int'(busy), 1);
            if (fb_we && kfirst < 0) begin
                kfirst = k;
                afirst = int'(fb_addr);
            end
            if (done) kdone = k;
        end
        chk("done_edge", kdone, 2 + exp_n);
        chk("busy_at_done", int'(busy), 0);
        chk("write_count", wr_count - w0, exp_n);
        if (exp_n > 0) begin
            chk("first_edge", kfirst, 2);
            chk("first_addr", afirst, exp_first);
        end else begin
            chk("no_write", kfirst, -1);
        end
        chk("sb_empty", sb.size(), 0);
        @(negedge clock); #1;
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int w0;
        int k;
        int dseen;

        vecs[0] = '{10, 5, 3, 2, 'hF0A, 6, 1610};
        vecs[1] = '{318, 239, 10, 10, 'h123, 2, 76798};
        vecs[2] = '{50, 50, 0, 5, 'hFFF, 0, 0};
        vecs[3] = '{320, 10, 5, 5, 'hABC, 0, 0};
        vecs[4] = '{100, 100, 5, 4, 'h5A5, 20, 32100};
        vecs[5] = '{0, 240, 3, 3, 'h111, 0, 0};
        vecs[6] = '{315, 0, 8, 3, 'h0F0, 15, 315};
        vecs[7] = '{0, 236, 2, 9, 'h00F, 8, 75520};
        vecs[8] = '{511, 255, 511, 255, 'h777, 0, 0};

        reset = 1'b1;
        start = 1'b0;
        x0 = '0;
        y0 = '0;
        width = '0;
        height = '0;
        color = '0;
        sync_vblank = 1'b0;
        vblank = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(fb_we), 0);
        chk("rst_addr", int'(fb_addr), 0);
        chk("rst_data", int'(fb_data), 0);
        reset = 1'b0;
        @(negedge clock); #1;

        for (int i = 0; i < 9; i++) begin
            run_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h,
                     vecs[i].color, vecs[i].exp_n, vecs[i].exp_first);
        end

        // Vblank-synchronised fill with an ignored start mid-fill.
        push_model(2, 3, 20, 2, 'h3C3, 1 << 30, n);
        chk("vb_model_n", n, 40);
        w0 = wr_count;
        vblank = 1'b0;
        drive_req(2, 3, 20, 2, 'h3C3, 1'b1);
        repeat (50) @(negedge clock);
        #1;
        chk("vb_no_write", wr_count - w0, 0);
        chk("vb_busy", int'(busy), 1);
        vblank = 1'b1;
        m = 0;
        while (!fb_we && m < 100) begin
            @(negedge clock); #1;
            m++;
        end
        chk("vb_first_edge", m, 3);
        chk("vb_first_addr", int'(fb_addr), 962);
        vblank = 1'b0;
        @(negedge clock); #1;
        drive_req(200, 100, 4, 4, 'h999, 1'b0);
        k = 0;
        while (!done && k < 200) begin
            @(negedge clock); #1;
            k++;
        end
        chk("vb_done", int'(done), 1);
        chk("vb_write_count", wr_count - w0, 40);
        chk("vb_sb_empty", sb.size(), 0);
        repeat (5) @(negedge clock);
        #1;
        chk("vb_stray_busy", int'(busy), 0);
        chk("vb_stray_writes", wr_count - w0, 40);

        // Full-screen fill interrupted by reset after 100 writes.
        push_model(0, 0, 320, 240, 'hEEE, 100, n);
        chk("full_model_n", n, 76800);
        w0 = wr_count;
        drive_req(0, 0, 320, 240, 'hEEE, 1'b0);
        k = 0;
        while (wr_count - w0 < 100 && k < 500) begin
            @(negedge clock); #1;
            k++;
        end
        chk("pre_reset_writes", wr_count - w0, 100);
        reset = 1'b1;
        @(negedge clock); #1;
        chk("rstmid_we", int'(fb_we), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_done", int'(done), 0);
        reset = 1'b0;
        dseen = 0;
        repeat (5) begin
            @(negedge clock); #1;
            if (done) dseen++;
        end
        chk("rstmid_no_done", dseen, 0);
        chk("rstmid_writes", wr_count - w0, 100);
        chk("rstmid_sb_empty", sb.size(), 0);
        run_fill(5, 7, 1, 1, 'h7E7, 1, 2245);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
